updown_count_monitor: RTL

Receive-side companion to the up/down counter. It samples the 4-bit count stream the counter drives and classifies every sample-to-sample step as up, down, hold or illegal. It reports the current direction, wrap-around events and run length of consecutive same-direction steps, and keeps a saturating error tally. It sits on the counter's output bus and gives datapath control and self-checking benches a registered view of counter behaviour.

---
 rtl/updown_mon_pkg.sv | 21 ++
 rtl/updown_count_monitor_step_classify.sv | 32 +++
 rtl/updown_count_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/updown_mon_pkg.sv
// Shared types and default sizes for the up/down count-stream monitor.
package updown_mon_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ERR_W = 8;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_UP    = 2'd2,
      ST_DOWN  = 2'd3
   } mon_state_e;

   typedef enum logic [1:0] {
      STEP_UP   = 2'd0,
      STEP_DOWN = 2'd1,
      STEP_HOLD = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

endpackage

// File: rtl/updown_count_monitor_step_classify.sv
// Combinational classifier for one sample-to-sample step of the count stream.
module step_classify
   import updown_mon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] prev_value,
   input  logic [WIDTH-1:0] cur_value,
   output step_e            step_class,
   output logic             step_wrap
);

   logic [WIDTH-1:0] delta;

   // Modular difference: +1 and -1 (all-ones) are the only legal moves.
   assign delta = cur_value - prev_value;

   always_comb begin
      step_class = STEP_ERR;
      step_wrap  = 1'b0;
      if (delta == WIDTH'(1)) begin
         step_class = STEP_UP;
         step_wrap  = (prev_value == {WIDTH{1'b1}});
      end else if (delta == {WIDTH{1'b1}}) begin
         step_class = STEP_DOWN;
         step_wrap  = (prev_value == '0);
      end else if (delta == '0) begin
         step_class = STEP_HOLD;
      end
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Registered monitor of an up/down counter output: direction, wrap, run length, error tally.
module updown_count_monitor
   import updown_mon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ERR_W = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_in,
   output logic             dir_up,
   output logic             dir_down,
   output logic             wrap,
   output logic             step_err,
   output logic [WIDTH-1:0] run_len,
   output logic [WIDTH-1:0] last_value,
   output logic [ERR_W-1:0] err_cnt
);

   mon_state_e       state_q, state_d;
   logic [WIDTH-1:0] last_value_q, last_value_d;
   logic [WIDTH-1:0] run_len_q, run_len_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             wrap_q, wrap_d;
   logic             step_err_q, step_err_d;

   step_e            cls;
   logic             cls_wrap;
   logic [WIDTH-1:0] run_len_inc;
   logic [ERR_W-1:0] err_cnt_inc;

   step_classify #(.WIDTH(WIDTH)) u_classify (
      .prev_value (last_value_q),
      .cur_value  (data_in),
      .step_class (cls),
      .step_wrap  (cls_wrap)
   );

   assign run_len_inc = (run_len_q == {WIDTH{1'b1}}) ? run_len_q : run_len_q + WIDTH'(1);
   assign err_cnt_inc = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_W'(1);

   always_comb begin
      state_d      = state_q;
      last_value_d = last_value_q;
      run_len_d    = run_len_q;
      err_cnt_d    = err_cnt_q;
      wrap_d       = 1'b0;
      step_err_d   = 1'b0;
      if (clr) begin
         state_d      = ST_EMPTY;
         last_value_d = '0;
         run_len_d    = '0;
      end else if (en) begin
         last_value_d = data_in;
         if (state_q == ST_EMPTY) begin
            // First sample after reset/clear only seeds the history.
            state_d   = ST_HOLD;
            run_len_d = '0;
         end else begin
            unique case (cls)
               STEP_UP: begin
                  state_d   = ST_UP;
                  run_len_d = (state_q == ST_UP) ? run_len_inc : WIDTH'(1);
                  wrap_d    = cls_wrap;
               end
               STEP_DOWN: begin
                  state_d   = ST_DOWN;
                  run_len_d = (state_q == ST_DOWN) ? run_len_inc : WIDTH'(1);
                  wrap_d    = cls_wrap;
               end
               STEP_HOLD: ;
               STEP_ERR: begin
                  state_d    = ST_HOLD;
                  run_len_d  = '0;
                  step_err_d = 1'b1;
                  err_cnt_d  = err_cnt_inc;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         last_value_q <= '0;
         run_len_q    <= '0;
         err_cnt_q    <= '0;
         wrap_q       <= 1'b0;
         step_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_value_q <= last_value_d;
         run_len_q    <= run_len_d;
         err_cnt_q    <= err_cnt_d;
         wrap_q       <= wrap_d;
         step_err_q   <= step_err_d;
      end
   end

   // Direction flags decode the state register only, so they are glitch-free registered views.
   assign dir_up     = (state_q == ST_UP);
   assign dir_down   = (state_q == ST_DOWN);
   assign wrap       = wrap_q;
   assign step_err   = step_err_q;
   assign run_len    = run_len_q;
   assign last_value = last_value_q;
   assign err_cnt    = err_cnt_q;

endmodule
